// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the DMA initiator.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_FINISH  = 3'd5
  } dma_state_t;

  // Word-align a byte address (low two bits are don't-care on input).
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite word-copy initiator: read one word, write it, repeat.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start; bus idle
// ST_RD_ADDR | read address phase (NONSEQ, HADDR=src)
// ST_RD_DATA | read data phase; capture HRDATA when HREADY
// ST_WR_ADDR | write address phase (NONSEQ, HADDR=dst)
// ST_WR_DATA | write data phase; HWDATA=buffer until HREADY
// ST_FINISH  | one-cycle done pulse, then back to idle
module ahb_dma_master
  import ahb_pkg::*;
#(
  parameter int MAX_LEN_W = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [MAX_LEN_W-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          HADDR,
  output logic                 HWRITE,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  dma_state_t           state;
  htrans_t              htrans_q;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [31:0]          buf_q;
  logic [MAX_LEN_W-1:0] count_q;

  assign HTRANS = htrans_q;
  assign HSIZE  = HSIZE_WORD;

  // Transfer sequencer; every bus output is set on entry to the state that owns it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      buf_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q   <= word_align(src_addr);
            dst_q   <= word_align(dst_addr);
            count_q <= len;
            err     <= 1'b0;
            busy    <= 1'b1;
            if (len == '0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state    <= ST_RD_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              HWRITE   <= 1'b0;
              HADDR    <= word_align(src_addr);
            end
          end
        end
        ST_RD_ADDR: begin
          state    <= ST_RD_DATA;
          htrans_q <= HTRANS_IDLE;
        end
        ST_RD_DATA: begin
          if (HREADY) begin
            if (HRESP) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              buf_q    <= HRDATA;
              src_q    <= src_q + 32'd4;
              state    <= ST_WR_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              HWRITE   <= 1'b1;
              HADDR    <= dst_q;
            end
          end
        end
        ST_WR_ADDR: begin
          state    <= ST_WR_DATA;
          htrans_q <= HTRANS_IDLE;
          HWDATA   <= buf_q;
        end
        ST_WR_DATA: begin
          if (HREADY) begin
            HWDATA  <= '0;
            dst_q   <= dst_q + 32'd4;
            count_q <= count_q - 1'b1;
            if (HRESP) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else if (count_q == MAX_LEN_W'(1)) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              state    <= ST_RD_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              HWRITE   <= 1'b0;
              HADDR    <= src_q;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          htrans_q <= HTRANS_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Directed bench for ahb_dma_master with a small AHB-Lite memory slave.
module tb_ahb_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  ahb_dma_master #(.MAX_LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // slave configuration, driven by the stimulus process
  logic [31:0] rmem [1024];
  int          wait_cfg = 0;
  int          err_rd = -1;

  // slave state and logs, written only by the slave process
  logic        dp_valid, dp_write, dp_err, dp_first;
  logic [31:0] dp_addr;
  int          waits_left;
  logic [31:0] hw_prev = '0;
  logic [31:0] rd_addr_log [64];
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];
  int          rd_cnt = 0, wr_cnt = 0, nonseq_cnt = 0, dp_cycles = 0, hwdata_bad = 0;

  assign HREADY = !(dp_valid && waits_left != 0);
  assign HRESP  = dp_valid && dp_err && HREADY;
  assign HRDATA = (dp_valid && !dp_write) ? rmem[dp_addr[11:2]] : 32'h0;

  // AHB-Lite slave: latch address phase, stall wait_cfg cycles, log writes
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_err     <= 1'b0;
      dp_first   <= 1'b0;
      dp_addr    <= '0;
      waits_left <= 0;
    end else begin
      if (dp_valid) begin
        dp_cycles <= dp_cycles + 1;
        if (dp_write) begin
          if (!dp_first && HWDATA !== hw_prev) hwdata_bad <= hwdata_bad + 1;
          hw_prev  <= HWDATA;
          dp_first <= 1'b0;
        end
        if (HREADY) begin
          dp_valid <= 1'b0;
          if (dp_write) begin
            wr_addr_log[wr_cnt[5:0]] <= dp_addr;
            wr_data_log[wr_cnt[5:0]] <= HWDATA;
            wr_cnt <= wr_cnt + 1;
          end
        end else begin
          waits_left <= waits_left - 1;
        end
      end
      if (HTRANS == 2'b10) begin
        nonseq_cnt <= nonseq_cnt + 1;
        dp_valid   <= 1'b1;
        dp_write   <= HWRITE;
        dp_addr    <= HADDR;
        waits_left <= wait_cfg;
        dp_first   <= 1'b1;
        dp_err     <= !HWRITE && (rd_cnt == err_rd);
        if (!HWRITE) begin
          rd_addr_log[rd_cnt[5:0]] <= HADDR;
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Launch a copy, return the cycle (1 = first cycle after accept edge) where done is seen
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input bit hold_start, output int cyc, output logic err_at_done);
    int k;
    @(negedge HCLK);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(posedge HCLK);
    #1;
    if (!hold_start) start = 1'b0;
    if (n != 16'd0) chk("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 400) begin
      @(posedge HCLK);
      #1;
      k++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    cyc = k + 1;
    err_at_done = err;
    @(posedge HCLK);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int          cyc, b, r, ns, dc, hb, k;
    logic        e;

    for (int i = 0; i < 1024; i++) rmem[i] = 32'h1000_0000 + i;

    // reset values
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_haddr",  HADDR,       32'h0);
    chk("rst_hwdata", HWDATA,      32'h0);
    chk("rst_hsize",  32'(HSIZE),  32'd2);
    @(negedge HCLK);
    HRESET = 1'b0;

    // 4-word copy, zero wait; start held high to show it is ignored while busy
    for (int i = 0; i < 4; i++) rmem[10'h40 + i] = 32'hA0 + i;
    b = wr_cnt;
    run(32'h0000_0100, 32'h0001_0000, 16'd4, 1'b1, cyc, e);
    chk("t1_done_cycle", cyc, 32'd17);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_wr_count", wr_cnt - b, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_waddr", wr_addr_log[6'(b + i)], 32'h0001_0000 + 32'(4 * i));
      chk("t1_wdata", wr_data_log[6'(b + i)], 32'hA0 + 32'(i));
    end

    // len=0: done next cycle, no bus traffic
    ns = nonseq_cnt;
    run(32'h0000_0100, 32'h0001_0000, 16'd0, 1'b0, cyc, e);
    chk("t2_done_cycle", cyc, 32'd1);
    chk("t2_no_nonseq", nonseq_cnt - ns, 32'd0);
    chk("t2_htrans", 32'(HTRANS), 32'd0);

    // 1 word with 2 wait states per data phase
    rmem[10'h140] = 32'hC5C5_0001;
    wait_cfg = 2;
    b = wr_cnt; dc = dp_cycles; hb = hwdata_bad;
    run(32'h0000_0500, 32'h0000_0600, 16'd1, 1'b0, cyc, e);
    chk("t3_done_cycle", cyc, 32'd9);
    chk("t3_dp_cycles", dp_cycles - dc, 32'd6);
    chk("t3_hwdata_stable", hwdata_bad - hb, 32'd0);
    chk("t3_wdata", wr_data_log[6'(b)], 32'hC5C5_0001);
    chk("t3_hwdata_idle", HWDATA, 32'h0);
    wait_cfg = 0;

    // error on read of word 2 of 3
    for (int i = 0; i < 3; i++) rmem[10'hC0 + i] = 32'hB0 + i;
    b = wr_cnt;
    err_rd = rd_cnt + 1;
    run(32'h0000_0300, 32'h0000_0400, 16'd3, 1'b0, cyc, e);
    err_rd = -1;
    chk("t4_done_cycle", cyc, 32'd7);
    chk("t4_err", 32'(e), 32'd1);
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_wr_count", wr_cnt - b, 32'd1);
    chk("t4_waddr", wr_addr_log[6'(b)], 32'h0000_0400);
    chk("t4_wdata", wr_data_log[6'(b)], 32'hB0);

    // address wrap; unaligned src forced to word alignment; err cleared by start
    rmem[10'h3FF] = 32'hEEEE_0001;
    rmem[10'h000] = 32'hEEEE_0002;
    b = wr_cnt; r = rd_cnt;
    run(32'hFFFF_FFFF, 32'h0000_0200, 16'd2, 1'b0, cyc, e);
    chk("t5_done_cycle", cyc, 32'd9);
    chk("t5_err", 32'(e), 32'd0);
    chk("t5_raddr0", rd_addr_log[6'(r)], 32'hFFFF_FFFC);
    chk("t5_raddr1", rd_addr_log[6'(r + 1)], 32'h0000_0000);
    chk("t5_wdata0", wr_data_log[6'(b)], 32'hEEEE_0001);
    chk("t5_wdata1", wr_data_log[6'(b + 1)], 32'hEEEE_0002);

    // reset asserted during write data phase
    wait_cfg = 2;
    @(negedge HCLK);
    src_addr = 32'h0000_0100; dst_addr = 32'h0000_0700; len = 16'd3; start = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    k = 0;
    while (!(dp_valid && dp_write) && k < 100) begin
      @(posedge HCLK);
      #1;
      k++;
    end
    chk("t6_reached_wr_data", 32'(dp_valid && dp_write), 32'd1);
    HRESET = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_htrans", 32'(HTRANS), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(posedge HCLK);
    #1;
    chk("t6_busy_next", 32'(busy), 32'd0);
    chk("t6_done_next", 32'(done), 32'd0);
    chk("t6_err_next", 32'(err), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    wait_cfg = 0;
    b = wr_cnt;
    run(32'h0000_0100, 32'h0000_0800, 16'd2, 1'b0, cyc, e);
    chk("t6_clean_cycle", cyc, 32'd9);
    chk("t6_clean_err", 32'(e), 32'd0);
    chk("t6_clean_wdata0", wr_data_log[6'(b)], 32'hA0);
    chk("t6_clean_wdata1", wr_data_log[6'(b + 1)], 32'hA1);
    chk("t6_clean_waddr1", wr_addr_log[6'(b + 1)], 32'h0000_0804);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ahb_dma_master.md
# ahb_dma_master

Single-channel AHB-Lite bus initiator that copies a block of 32-bit words from a source address to a destination address, one word at a time, read then write. It sits on the initiator side of the AHB-Lite bus and drives HADDR/HWRITE/HWDATA into the existing decoder/ROM/RAM fabric, consuming HRDATA. A simple start/busy/done/err interface lets software-visible control logic or a testbench launch transfers.

## Interface
- MAX_LEN_W, 16: width of the word-count input; maximum transfer is 2^MAX_LEN_W-1 words.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- start  in  1  launch request, sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len  in  MAX_LEN_W  number of words to copy.
- busy  out  1  high from the cycle after accepted start until done pulse.
- done  out  1  one-cycle pulse at end of transfer (success or error).
- err  out  1  sticky error flag; set on HRESP error; cleared by next accepted start.
- HADDR  out  32  bus address.
- HWRITE  out  1  1 = write transfer.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HSIZE  out  3  constant 3'b010 (word).
- HWDATA  out  32  write data, valid in write data phase.
- HRDATA  in  32  read data from the decoder mux.
- HREADY  in  1  data phase completes when high.
- HRESP  in  1  1 = error response.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
- IDLE: on start=1, latch src/dst (low bits zeroed), count=len, clear err. len=0 -> FINISH directly; else -> RD_ADDR.
- RD_ADDR: HTRANS=NONSEQ, HWRITE=0, HADDR=src -> RD_DATA unconditionally.
- RD_DATA: HTRANS=IDLE; hold while HREADY=0; on HREADY=1 capture HRDATA into data buffer, src+=4 -> WR_ADDR (or FINISH with err=1 if HRESP=1).
- WR_ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=dst -> WR_DATA.
- WR_DATA: HWDATA=buffer, HTRANS=IDLE; hold while HREADY=0; on HREADY=1 dst+=4, count-=1; HRESP=1 -> err=1, FINISH; count reaching 0 -> FINISH; else -> RD_ADDR.
- FINISH: done=1 for one cycle -> IDLE.
- Address increment is modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000, no error).
- start while not IDLE is ignored (no queueing).
- HADDR/HWRITE hold last address-phase value during data phase (registered in fabric anyway); HWDATA is 0 outside WR_DATA.

## Timing
- Reset values: busy=0, done=0, err=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=3'b010; FSM in IDLE.
- Zero-wait-state word copy: 4 cycles (RD_ADDR, RD_DATA, WR_ADDR, WR_DATA); N words -> 4N cycles + 1 FINISH cycle; done asserted 4N+1 cycles after start-accept edge.
- len=0: done pulses the cycle after start accepted; no NONSEQ issued.
- Each HREADY=0 cycle in a data phase adds exactly one cycle.
- HRESP sampled only with HREADY=1 in a data phase.
- HRESET mid-transfer: immediately IDLE, HTRANS=IDLE, no done pulse, err=0.
- Outputs are registered (driven from state/flops), no combinational path from HRDATA/HREADY to HADDR/HTRANS.

## Structure
- Shared package ahb_pkg: htrans_t enum (HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10), HSIZE_WORD=3'b010, dma_state_t enum of the six states.
- Single module; no sub-module needed; address/count registers inline in the FSM's always_ff.

## Test plan
- Copy 4 words src=0x0000_0100 to dst=0x0001_0000 against RAM preloaded 0xA0..0xA3, HREADY=1 -> RAM[dst..dst+12]=0xA0..0xA3, done pulse at cycle 17, err=0.
- len=0, start=1 -> done next cycle, HTRANS stays IDLE throughout, busy never rises beyond that cycle.
- Insert 2 HREADY=0 cycles in each data phase of a 1-word copy -> completion at cycle 9, HWDATA held stable through waits.
- HRESP=1 on read data phase of word 2 of 3 -> err=1, done pulse, word 1 written, words 2-3 not written.
- src=0xFFFF_FFFC, len=2 -> second read HADDR=0x0000_0000 (wrap), no error.
- Assert HRESET during WR_DATA -> next cycle busy=0, HTRANS=IDLE, no done; subsequent start runs a clean copy.
